cabac_byte_writer: RTL and testbench

//  Encoder-side counterpart of the CABAC decoder byte-read path: accepts 9-bit lead

---
 rtl/cabac_enc_pkg.sv | 16 +
 rtl/cbw_out_reg.sv | 25 ++
 rtl/cabac_byte_writer.sv | 142 ++++++++++++++
 tb/tb_cabac_byte_writer.sv | 320 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cabac_enc_pkg.sv
// Shared CABAC encoder definitions: byte-writer FSM states and byte constants.
package cabac_enc_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_EMIT_BUF,
    S_EMIT_RUN,
    S_FLUSH_BUF,
    S_FLUSH_RUN,
    S_DONE
  } cbw_state_t;

  localparam logic [7:0] CBW_FF   = 8'hFF;
  localparam logic [7:0] CBW_ZERO = 8'h00;

endpackage

// File: rtl/cbw_out_reg.sv
// Output byte holding register: loads a new byte on request and keeps it
// stable until the downstream handshake completes.
module cbw_out_reg (
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic [7:0] load_byte,
  input  logic       byte_ready_i,
  output logic       byte_valid_o,
  output logic [7:0] byte_o
);

  always_ff @(posedge clk) begin
    if (rst) begin
      byte_valid_o <= 1'b0;
      byte_o       <= '0;
    end else if (load) begin
      byte_valid_o <= 1'b1;
      byte_o       <= load_byte;
    end else if (byte_valid_o && byte_ready_i) begin
      byte_valid_o <= 1'b0;
    end
  end

endmodule

// File: rtl/cabac_byte_writer.sv
// CABAC byte writer: resolves carries over a buffered byte plus a run of 0xFF
// bytes and streams final bitstream bytes. Optional CBW_BYTE_CNT_EN adds byte_cnt_o.
module cabac_byte_writer #(
  parameter int unsigned RUN_W = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       lead_valid_i,
  output logic       lead_ready_o,
  input  logic [8:0] lead_byte_i,
  input  logic       flush_i,
  input  logic       flush_carry_i,
  output logic       byte_valid_o,
  input  logic       byte_ready_i,
  output logic [7:0] byte_o,
  output logic       flush_done_o,
  output logic       err_o
`ifdef CBW_BYTE_CNT_EN
  , output logic [31:0] byte_cnt_o
`endif
);

  import cabac_enc_pkg::*;

  localparam logic [RUN_W-1:0] RUN_ONE = RUN_W'(1);

  cbw_state_t       state, state_nxt;
  logic [7:0]       buf_byte, buf_nxt, run_byte, run_nxt, load_byte;
  logic [RUN_W-1:0] num_buf, num_nxt, remaining, rem_nxt;
  logic             err_nxt, load, hs, in_flush;

  assign hs       = byte_valid_o && byte_ready_i;
  assign in_flush = (state == S_FLUSH_BUF) || (state == S_FLUSH_RUN);

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      buf_byte  <= CBW_FF;
      num_buf   <= '0;
      remaining <= '0;
      run_byte  <= CBW_FF;
      err_o     <= 1'b0;
    end else begin
      state     <= state_nxt;
      buf_byte  <= buf_nxt;
      num_buf   <= num_nxt;
      remaining <= rem_nxt;
      run_byte  <= run_nxt;
      err_o     <= err_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    buf_nxt      = buf_byte;
    num_nxt      = num_buf;
    rem_nxt      = remaining;
    run_nxt      = run_byte;
    err_nxt      = err_o;
    load         = 1'b0;
    load_byte    = buf_byte;
    lead_ready_o = (state == S_IDLE) && !rst;
    flush_done_o = (state == S_DONE);

    unique case (state)
      S_IDLE: begin
        if (lead_valid_i) begin
          if (lead_byte_i == 9'h0FF) begin
            // Saturate the run length rather than wrap; emission uses the held count.
            if (num_buf == '1) err_nxt = 1'b1;
            else               num_nxt = num_buf + RUN_ONE;
          end else if (num_buf == '0) begin
            buf_nxt = lead_byte_i[7:0];
            num_nxt = RUN_ONE;
            if (lead_byte_i[8]) err_nxt = 1'b1;
          end else begin
            load      = 1'b1;
            load_byte = buf_byte + {7'b0, lead_byte_i[8]};
            run_nxt   = lead_byte_i[8] ? CBW_ZERO : CBW_FF;
            rem_nxt   = num_buf - RUN_ONE;
            buf_nxt   = lead_byte_i[7:0];
            num_nxt   = RUN_ONE;
            state_nxt = S_EMIT_BUF;
          end
        end else if (flush_i) begin
          if (flush_carry_i) begin
            load      = 1'b1;
            load_byte = buf_byte + 8'd1;
            run_nxt   = CBW_ZERO;
            rem_nxt   = (num_buf == '0) ? '0 : num_buf - RUN_ONE;
            if (num_buf == '0) err_nxt = 1'b1;
            state_nxt = S_FLUSH_BUF;
          end else if (num_buf != '0) begin
            load      = 1'b1;
            load_byte = buf_byte;
            run_nxt   = CBW_FF;
            rem_nxt   = num_buf - RUN_ONE;
            state_nxt = S_FLUSH_BUF;
          end else begin
            state_nxt = S_DONE;
          end
        end
      end
      S_EMIT_BUF, S_EMIT_RUN, S_FLUSH_BUF, S_FLUSH_RUN: begin
        if (hs) begin
          if (remaining != '0) begin
            load      = 1'b1;
            load_byte = run_byte;
            rem_nxt   = remaining - RUN_ONE;
            state_nxt = in_flush ? S_FLUSH_RUN : S_EMIT_RUN;
          end else begin
            state_nxt = in_flush ? S_DONE : S_IDLE;
          end
        end
      end
      S_DONE: begin
        num_nxt   = '0;
        buf_nxt   = CBW_FF;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  cbw_out_reg u_out_reg (
    .clk          (clk),
    .rst          (rst),
    .load         (load),
    .load_byte    (load_byte),
    .byte_ready_i (byte_ready_i),
    .byte_valid_o (byte_valid_o),
    .byte_o       (byte_o)
  );

`ifdef CBW_BYTE_CNT_EN
  always_ff @(posedge clk) begin
    if (rst)     byte_cnt_o <= '0;
    else if (hs) byte_cnt_o <= byte_cnt_o + 32'd1;
  end
`endif

endmodule

// File: tb/tb_cabac_byte_writer.sv
// Self-checking bench for cabac_byte_writer: directed scenarios plus randomized
// lead/flush traffic scored against a byte-level reference model.
module tb_cabac_byte_writer;

  localparam int MAXN = 65535;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, lead_valid, flush, flush_carry, byte_ready;
  logic [8:0] lead_byte;
  logic       lead_ready, byte_valid, flush_done, err;
  logic [7:0] byte_out;
`ifdef CBW_BYTE_CNT_EN
  logic [31:0] byte_cnt;
`endif

  logic       rst2, lead_valid2, byte_ready2;
  logic [8:0] lead_byte2;
  logic       lead_ready2, byte_valid2, flush_done2, err2;
  logic [7:0] byte_out2;
`ifdef CBW_BYTE_CNT_EN
  logic [31:0] byte_cnt2;
`endif

  cabac_byte_writer dut (
    .clk(clk), .rst(rst), .lead_valid_i(lead_valid), .lead_ready_o(lead_ready),
    .lead_byte_i(lead_byte), .flush_i(flush), .flush_carry_i(flush_carry),
    .byte_valid_o(byte_valid), .byte_ready_i(byte_ready), .byte_o(byte_out),
    .flush_done_o(flush_done), .err_o(err)
`ifdef CBW_BYTE_CNT_EN
    , .byte_cnt_o(byte_cnt)
`endif
  );

  cabac_byte_writer #(.RUN_W(2)) dut2 (
    .clk(clk), .rst(rst2), .lead_valid_i(lead_valid2), .lead_ready_o(lead_ready2),
    .lead_byte_i(lead_byte2), .flush_i(1'b0), .flush_carry_i(1'b0),
    .byte_valid_o(byte_valid2), .byte_ready_i(byte_ready2), .byte_o(byte_out2),
    .flush_done_o(flush_done2), .err_o(err2)
`ifdef CBW_BYTE_CNT_EN
    , .byte_cnt_o(byte_cnt2)
`endif
  );

  int checks = 0, passes = 0, timeouts = 0, done_cnt = 0, rmode = 0;
  logic [7:0] got[$], exp_q[$], got2[$];
  logic [7:0] m_buf;
  int         m_n;
  logic       m_err;

  // Downstream ready pattern: 0 = always, 1 = toggling, 2 = random.
  initial begin
    byte_ready = 1'b1;
    forever begin
      @(posedge clk); #2;
      case (rmode)
        0:       byte_ready = 1'b1;
        1:       byte_ready = ~byte_ready;
        default: byte_ready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  always @(negedge clk) begin
    if (!rst && byte_valid && byte_ready) got.push_back(byte_out);
    if (!rst && flush_done) done_cnt++;
    if (!rst2 && byte_valid2 && byte_ready2) got2.push_back(byte_out2);
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic model_lead(input logic [8:0] l);
    logic [7:0] t;
    if (l == 9'h0FF) begin
      if (m_n == MAXN) m_err = 1'b1; else m_n++;
    end else if (m_n == 0) begin
      m_buf = l[7:0]; m_n = 1;
      if (l[8]) m_err = 1'b1;
    end else begin
      t = m_buf + {7'b0, l[8]};
      exp_q.push_back(t);
      for (int i = 1; i < m_n; i++) exp_q.push_back(l[8] ? 8'h00 : 8'hFF);
      m_buf = l[7:0]; m_n = 1;
    end
  endtask

  task automatic model_flush(input logic c);
    logic [7:0] t;
    if (c) begin
      t = m_buf + 8'd1;
      exp_q.push_back(t);
      if (m_n == 0) m_err = 1'b1;
      for (int i = 1; i < m_n; i++) exp_q.push_back(8'h00);
    end else if (m_n > 0) begin
      exp_q.push_back(m_buf);
      for (int i = 1; i < m_n; i++) exp_q.push_back(8'hFF);
    end
    m_n = 0; m_buf = 8'hFF;
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; lead_valid = 1'b0; flush = 1'b0; flush_carry = 1'b0; lead_byte = '0;
    tick(); tick();
    rst = 1'b0;
    got.delete(); exp_q.delete();
    m_n = 0; m_buf = 8'hFF; m_err = 1'b0; done_cnt = 0;
  endtask

  task automatic wait_ready();
    int w = 0;
    while (!lead_ready && w < 500) begin tick(); w++; end
    if (!lead_ready) timeouts++;
  endtask

  task automatic send_lead(input logic [8:0] l);
    wait_ready();
    lead_valid = 1'b1; lead_byte = l;
    tick();
    lead_valid = 1'b0;
    model_lead(l);
  endtask

  task automatic do_flush(input logic c);
    int w = 0, d0;
    wait_ready();
    d0 = done_cnt;
    flush = 1'b1; flush_carry = c;
    tick();
    flush = 1'b0;
    model_flush(c);
    while (done_cnt == d0 && w < 500) begin tick(); w++; end
    if (done_cnt == d0) timeouts++;
  endtask

  task automatic drain();
    int w = 0;
    while (!(lead_ready && !byte_valid) && w < 500) begin tick(); w++; end
    if (!(lead_ready && !byte_valid)) timeouts++;
  endtask

  task automatic test_reset();
    do_reset();
    send_lead(9'h155);   // carry with empty buffer raises err_o before reset
    rst = 1'b1;
    tick();
    checks++; if (lead_ready !== 1'b0) $display("FAIL reset_lead_ready: got %b expected 0", lead_ready); else passes++;
    checks++; if (byte_valid !== 1'b0) $display("FAIL reset_byte_valid: got %b expected 0", byte_valid); else passes++;
    checks++; if (byte_out !== 8'h00) $display("FAIL reset_byte_o: got %h expected 00", byte_out); else passes++;
    checks++; if (flush_done !== 1'b0) $display("FAIL reset_flush_done: got %b expected 0", flush_done); else passes++;
    checks++; if (err !== 1'b0) $display("FAIL reset_err: got %b expected 0", err); else passes++;
    rst = 1'b0;
    tick();
    checks++; if (lead_ready !== 1'b1) $display("FAIL post_reset_ready: got %b expected 1", lead_ready); else passes++;
  endtask

  task automatic test_single_byte();
    do_reset(); rmode = 0;
    send_lead(9'h012);
    send_lead(9'h034);
    checks++; if (lead_ready !== 1'b0) $display("FAIL t1_ready_low: got %b expected 0", lead_ready); else passes++;
    checks++; if (byte_valid !== 1'b1 || byte_out !== 8'h12)
      $display("FAIL t1_first_byte: got v=%b %h expected v=1 12", byte_valid, byte_out); else passes++;
    tick();
    checks++; if (lead_ready !== 1'b1 || byte_valid !== 1'b0)
      $display("FAIL t1_ready_back: got ready=%b valid=%b expected 1 0", lead_ready, byte_valid); else passes++;
    do_flush(1'b0); drain();
    checks++; if (got.size() !== exp_q.size()) $display("FAIL t1_count: got %0d expected %0d", got.size(), exp_q.size()); else passes++;
    for (int i = 0; i < exp_q.size() && i < got.size(); i++) begin
      checks++; if (got[i] !== exp_q[i]) $display("FAIL t1_byte%0d: got %h expected %h", i, got[i], exp_q[i]); else passes++;
    end
  endtask

  task automatic test_carry_run();
    do_reset(); rmode = 0;
    send_lead(9'h0A0); send_lead(9'h0FF); send_lead(9'h0FF); send_lead(9'h105);
    drain();
    do_flush(1'b0); drain();
    checks++; if (got.size() !== exp_q.size()) $display("FAIL t2_count: got %0d expected %0d", got.size(), exp_q.size()); else passes++;
    for (int i = 0; i < exp_q.size() && i < got.size(); i++) begin
      checks++; if (got[i] !== exp_q[i]) $display("FAIL t2_byte%0d: got %h expected %h", i, got[i], exp_q[i]); else passes++;
    end
  endtask

  task automatic test_flush_no_carry();
    do_reset(); rmode = 0;
    send_lead(9'h0A0); send_lead(9'h0FF); send_lead(9'h012);
    do_flush(1'b0); drain();
    repeat (3) tick();
    checks++; if (done_cnt !== 1) $display("FAIL t3_done_pulses: got %0d expected 1", done_cnt); else passes++;
    checks++; if (got.size() !== exp_q.size()) $display("FAIL t3_count: got %0d expected %0d", got.size(), exp_q.size()); else passes++;
    for (int i = 0; i < exp_q.size() && i < got.size(); i++) begin
      checks++; if (got[i] !== exp_q[i]) $display("FAIL t3_byte%0d: got %h expected %h", i, got[i], exp_q[i]); else passes++;
    end
    do_flush(1'b0);   // empty flush: no bytes, pulse only
    repeat (3) tick();
    checks++; if (done_cnt !== 2) $display("FAIL t3_empty_flush_done: got %0d expected 2", done_cnt); else passes++;
  endtask

  task automatic test_backpressure();
    do_reset(); rmode = 1;
    fork
      begin
        send_lead(9'h0A0); send_lead(9'h0FF); send_lead(9'h0FF); send_lead(9'h105);
        do_flush(1'b0); drain();
      end
      begin
        logic pv = 1'b0, pr = 1'b0;
        logic [7:0] pb = '0;
        repeat (60) begin
          @(negedge clk);
          if (pv && !pr) begin
            checks++;
            if (byte_valid !== 1'b1 || byte_out !== pb)
              $display("FAIL t4_hold: got v=%b %h expected v=1 %h", byte_valid, byte_out, pb);
            else passes++;
          end
          pv = byte_valid; pr = byte_ready; pb = byte_out;
        end
      end
    join
    rmode = 0;
    checks++; if (got.size() !== exp_q.size()) $display("FAIL t4_count: got %0d expected %0d", got.size(), exp_q.size()); else passes++;
    for (int i = 0; i < exp_q.size() && i < got.size(); i++) begin
      checks++; if (got[i] !== exp_q[i]) $display("FAIL t4_byte%0d: got %h expected %h", i, got[i], exp_q[i]); else passes++;
    end
  endtask

  task automatic test_flush_carry();
    do_reset(); rmode = 0;
    send_lead(9'h0FE); send_lead(9'h0FF);
    do_flush(1'b1); drain();
    checks++; if (got.size() !== 2) $display("FAIL t6_count: got %0d expected 2", got.size()); else passes++;
    checks++; if (got.size() == 2 && (got[0] !== 8'hFF || got[1] !== 8'h00))
      $display("FAIL t6_bytes: got %h %h expected ff 00", got[0], got[1]); else passes++;
`ifdef CBW_BYTE_CNT_EN
    checks++; if (byte_cnt !== 32'd2) $display("FAIL t6_byte_cnt: got %0d expected 2", byte_cnt); else passes++;
`endif
  endtask

  task automatic test_saturation();
    logic [8:0] seq [6] = '{9'h010, 9'h0FF, 9'h0FF, 9'h0FF, 9'h0FF, 9'h020};
    logic [7:0] exp2 [3] = '{8'h10, 8'hFF, 8'hFF};
    int w = 0;
    rst2 = 1'b1; lead_valid2 = 1'b0; lead_byte2 = '0; byte_ready2 = 1'b1;
    tick(); tick(); rst2 = 1'b0; got2.delete();
    for (int i = 0; i < 6; i++) begin
      while (!lead_ready2 && w < 200) begin tick(); w++; end
      lead_valid2 = 1'b1; lead_byte2 = seq[i];
      tick();
      lead_valid2 = 1'b0;
    end
    while ((!lead_ready2 || byte_valid2) && w < 200) begin tick(); w++; end
    if (w >= 200) timeouts++;
    checks++; if (err2 !== 1'b1) $display("FAIL t5_err: got %b expected 1", err2); else passes++;
    checks++; if (got2.size() !== 3) $display("FAIL t5_count: got %0d expected 3", got2.size()); else passes++;
    for (int i = 0; i < 3 && i < got2.size(); i++) begin
      checks++; if (got2[i] !== exp2[i]) $display("FAIL t5_byte%0d: got %h expected %h", i, got2[i], exp2[i]); else passes++;
    end
    byte_ready2 = 1'b0;
    lead_valid2 = 1'b1; lead_byte2 = 9'h0FF; tick();
    lead_byte2 = 9'h030; tick();
    lead_valid2 = 1'b0; tick();
    checks++; if (byte_valid2 !== 1'b1) $display("FAIL t5_stalled_valid: got %b expected 1", byte_valid2); else passes++;
    rst2 = 1'b1; tick();
    checks++; if (byte_valid2 !== 1'b0 || err2 !== 1'b0)
      $display("FAIL t5_abort: got valid=%b err=%b expected 0 0", byte_valid2, err2); else passes++;
    rst2 = 1'b0; byte_ready2 = 1'b1; tick(); tick();
    checks++; if (byte_valid2 !== 1'b0 || got2.size() !== 3)
      $display("FAIL t5_discard: got valid=%b count=%0d expected 0 3", byte_valid2, got2.size()); else passes++;
  endtask

  task automatic test_random();
    int nflush = 0;
    do_reset(); rmode = 2;
    for (int it = 0; it < 12; it++) begin
      int nl = $urandom_range(1, 6);
      for (int k = 0; k < nl; k++) begin
        if ($urandom_range(0, 99) < 45) send_lead(9'h0FF);
        else send_lead(9'($urandom_range(0, 511)));
      end
      if ($urandom_range(0, 2) == 0) begin
        do_flush(1'($urandom_range(0, 1))); nflush++;
      end
    end
    do_flush(1'($urandom_range(0, 1))); nflush++;
    drain();
    rmode = 0;
    checks++; if (got.size() !== exp_q.size()) $display("FAIL rand_count: got %0d expected %0d", got.size(), exp_q.size()); else passes++;
    for (int i = 0; i < exp_q.size() && i < got.size(); i++) begin
      checks++; if (got[i] !== exp_q[i]) $display("FAIL rand_byte%0d: got %h expected %h", i, got[i], exp_q[i]); else passes++;
    end
    checks++; if (err !== m_err) $display("FAIL rand_err: got %b expected %b", err, m_err); else passes++;
    checks++; if (done_cnt !== nflush) $display("FAIL rand_done: got %0d expected %0d", done_cnt, nflush); else passes++;
  endtask

  initial begin
    rst2 = 1'b1; lead_valid2 = 1'b0; lead_byte2 = '0; byte_ready2 = 1'b1;
    test_reset();
    test_single_byte();
    test_carry_run();
    test_flush_no_carry();
    test_backpressure();
    test_flush_carry();
    test_saturation();
    test_random();
    checks++; if (timeouts !== 0) $display("FAIL handshake_timeouts: got %0d expected 0", timeouts); else passes++;
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
